cdiv: RTL and testbench

- Sequential complex divider; the inverse operation of the team's packed complex multiplier.
- Operands and results use the same packing: real part in the upper WIDTH/2 bits, imaginary part in the lower WIDTH/2 bits, each a signed two's-complement integer.
- Computes q = a / b as an integer quotient per component, using a start/done handshake and a fixed latency.
- Sits alongside the complex multiplier in the arithmetic datapath.

---
 rtl/cdiv_pkg.sv | 18 +
 rtl/cdiv_if.sv | 19 +
 rtl/cdiv_seq_udiv.sv | 45 ++++
 rtl/cdiv.sv | 163 ++++++++++++++++
 tb/tb_cdiv.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/cdiv_pkg.sv
// Shared types and sizing helpers for the sequential complex divider.
package cdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Iteration counter width; covers packed widths up to 64 bits.
  localparam int ITER_W = 6;

  function automatic int half_width(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/cdiv_if.sv
// Start/done handshake and operand/result bundle for cdiv.
interface cdiv_if #(
  parameter int WIDTH = 8
);
  localparam int H = cdiv_pkg::half_width(WIDTH);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [H-1:0]     quor;
  logic [H-1:0]     quoi;
  logic             div_zero;
  logic             ovf;

  modport master (output start, a, b, input busy, done, quor, quoi, div_zero, ovf);
  modport slave  (input start, a, b, output busy, done, quor, quoi, div_zero, ovf);
endinterface

// File: rtl/cdiv_seq_udiv.sv
// Unsigned restoring divider producing one quotient bit per step strobe.
module seq_udiv #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);
  logic [W-1:0] quo_r;
  logic [W-1:0] rem_r;
  logic [W:0]   shifted_s;
  logic [W:0]   trial_s;

  always_comb begin
    shifted_s = {rem_r, quo_r[W-1]};
    trial_s   = shifted_s - {1'b0, divisor};
  end

  // A clear sign bit on the trial subtraction means the divisor fits this step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_r <= {W{1'b0}};
      rem_r <= {W{1'b0}};
    end else if (load) begin
      quo_r <= dividend;
      rem_r <= {W{1'b0}};
    end else if (step) begin
      if (!trial_s[W]) begin
        rem_r <= trial_s[W-1:0];
        quo_r <= {quo_r[W-2:0], 1'b1};
      end else begin
        rem_r <= shifted_s[W-1:0];
        quo_r <= {quo_r[W-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_r;
  assign remainder = rem_r;
endmodule

// File: rtl/cdiv.sv
// Sequential packed complex divider: q = a / b per component, truncating toward zero,
// with a fixed start-to-done latency of 2H+2 enabled cycles.
module cdiv
  import cdiv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic   clk,
  input logic   rst_n,
  input logic   enable,
  cdiv_if.slave bus
);
  localparam int H  = half_width(WIDTH);
  localparam int W2 = 2 * H;
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(W2 - 1);
  localparam logic [W2-1:0]     POS_LIM   = W2'((32'd1 << (H - 1)) - 32'd1);
  localparam logic [W2-1:0]     NEG_LIM   = W2'(32'd1 << (H - 1));

  state_t              state_r, state_s;
  logic                load_s, step_s;
  logic [H-1:0]        ar_r, ai_r, br_r, bi_r;
  logic [ITER_W-1:0]   cnt_r;
  logic [W2-1:0]       d_r;
  logic                sr_r, si_r, dz_r;
  logic                busy_r, done_r, div_zero_r, ovf_r;
  logic [H-1:0]        quor_r, quoi_r;

  logic signed [W2:0]  are_s, aie_s, bre_s, bie_s, nr_s, ni_s;
  logic [W2-1:0]       brw_s, biw_s, d_s, nr_mag_s, ni_mag_s;
  logic [W2-1:0]       qr_s, qi_s, rem_re_unused_s, rem_im_unused_s;
  logic [H-1:0]        fr_s, fi_s;
  logic                ovf_s;

  // Numerators carry an extra bit so the sum of two products cannot overflow.
  always_comb begin
    are_s    = (W2 + 1)'($signed(ar_r));
    aie_s    = (W2 + 1)'($signed(ai_r));
    bre_s    = (W2 + 1)'($signed(br_r));
    bie_s    = (W2 + 1)'($signed(bi_r));
    nr_s     = are_s * bre_s + aie_s * bie_s;
    ni_s     = aie_s * bre_s - are_s * bie_s;
    brw_s    = W2'($signed(br_r));
    biw_s    = W2'($signed(bi_r));
    d_s      = brw_s * brw_s + biw_s * biw_s;
    nr_mag_s = nr_s[W2] ? W2'(-nr_s) : nr_s[W2-1:0];
    ni_mag_s = ni_s[W2] ? W2'(-ni_s) : ni_s[W2-1:0];
    fr_s     = sr_r ? ({H{1'b0}} - qr_s[H-1:0]) : qr_s[H-1:0];
    fi_s     = si_r ? ({H{1'b0}} - qi_s[H-1:0]) : qi_s[H-1:0];
    ovf_s    = (sr_r ? (qr_s > NEG_LIM) : (qr_s > POS_LIM)) |
               (si_r ? (qi_s > NEG_LIM) : (qi_s > POS_LIM));
  end

  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    step_s  = 1'b0;
    if (enable) begin
      case (state_r)
        IDLE: begin
          if (bus.start) state_s = MUL;
          else           state_s = IDLE;
        end
        MUL: begin
          load_s  = 1'b1;
          state_s = DIV;
        end
        DIV: begin
          step_s = 1'b1;
          if (cnt_r == LAST_ITER) state_s = DONE;
          else                    state_s = DIV;
        end
        DONE:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Operand capture, divider setup and result registers; everything freezes with enable low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_r       <= {H{1'b0}};
      ai_r       <= {H{1'b0}};
      br_r       <= {H{1'b0}};
      bi_r       <= {H{1'b0}};
      cnt_r      <= {ITER_W{1'b0}};
      d_r        <= {W2{1'b0}};
      sr_r       <= 1'b0;
      si_r       <= 1'b0;
      dz_r       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      ovf_r      <= 1'b0;
      quor_r     <= {H{1'b0}};
      quoi_r     <= {H{1'b0}};
    end else if (enable) begin
      done_r <= (state_r == DONE);
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            ar_r   <= bus.a[WIDTH-1:H];
            ai_r   <= bus.a[H-1:0];
            br_r   <= bus.b[WIDTH-1:H];
            bi_r   <= bus.b[H-1:0];
            busy_r <= 1'b1;
          end
        end
        MUL: begin
          sr_r  <= nr_s[W2];
          si_r  <= ni_s[W2];
          d_r   <= d_s;
          dz_r  <= (d_s == {W2{1'b0}});
          cnt_r <= {ITER_W{1'b0}};
        end
        DIV: cnt_r <= cnt_r + ITER_W'(1);
        DONE: begin
          busy_r     <= 1'b0;
          quor_r     <= dz_r ? {H{1'b0}} : fr_s;
          quoi_r     <= dz_r ? {H{1'b0}} : fi_s;
          div_zero_r <= dz_r;
          ovf_r      <= !dz_r && ovf_s;
        end
        default: busy_r <= 1'b0;
      endcase
    end
  end

  seq_udiv #(.W(W2)) u_div_re (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_s),
    .step      (step_s),
    .dividend  (nr_mag_s),
    .divisor   (d_r),
    .quotient  (qr_s),
    .remainder (rem_re_unused_s)
  );

  seq_udiv #(.W(W2)) u_div_im (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_s),
    .step      (step_s),
    .dividend  (ni_mag_s),
    .divisor   (d_r),
    .quotient  (qi_s),
    .remainder (rem_im_unused_s)
  );

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.quor     = quor_r;
  assign bus.quoi     = quoi_r;
  assign bus.div_zero = div_zero_r;
  assign bus.ovf      = ovf_r;
endmodule

// File: tb/tb_cdiv.sv
// Self-checking bench for cdiv: integer reference model, per-cycle output compare, directed cases.
module tb_cdiv;
  typedef struct packed {
    logic [3:0] qr;
    logic [3:0] qi;
    logic       dz;
    logic       ovf;
  } res_t;

  logic clk;
  logic rst_n;
  logic enable;
  int   n_vec;
  int   n_err;
  res_t exp_q[$];
  res_t held;
  logic done_prev;

  cdiv_if #(.WIDTH(8)) bus ();

  cdiv #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plain integer arithmetic; SV integer division truncates toward zero.
  function automatic res_t model(input logic [7:0] av, input logic [7:0] bv);
    int ar, ai, br, bi, nr, ni, d, qr, qi;
    res_t r;
    ar = int'($signed(av[7:4]));
    ai = int'($signed(av[3:0]));
    br = int'($signed(bv[7:4]));
    bi = int'($signed(bv[3:0]));
    nr = ar * br + ai * bi;
    ni = ai * br - ar * bi;
    d  = br * br + bi * bi;
    if (d == 0) begin
      r = '{qr: 4'h0, qi: 4'h0, dz: 1'b1, ovf: 1'b0};
    end else begin
      qr    = nr / d;
      qi    = ni / d;
      r.qr  = qr[3:0];
      r.qi  = qi[3:0];
      r.dz  = 1'b0;
      r.ovf = (qr < -8) || (qr > 7) || (qi < -8) || (qi > 7);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs must always equal the most recently delivered result (zero after reset).
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      held      = '0;
      done_prev = 1'b0;
    end else begin
      if (bus.done && !done_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          held = exp_q.pop_front();
        end
      end
      check("outputs", 32'({bus.quor, bus.quoi, bus.div_zero, bus.ovf}), 32'(held));
      done_prev = bus.done;
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge on which done rises.
  task automatic run_div(input logic [7:0] av, input logic [7:0] bv, input int exp_lat);
    int   lat;
    logic busy_ok;
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    exp_q.push_back(model(av, bv));
    @(posedge clk); #1;
    bus.start = 1'b0;
    busy_ok   = bus.busy;
    lat       = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) break;
      if (!bus.busy) busy_ok = 1'b0;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("busy_during_op", 32'(busy_ok), 32'd1);
    check("busy_low_at_done", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   lat;
    int   seen;
    logic busy_ok;
    logic [7:0] ra, rb;
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    enable    = 1'b1;
    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'({bus.busy, bus.done, bus.quor, bus.quoi, bus.div_zero, bus.ovf}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    check("model_62_11", 32'(model(8'h62, 8'h11)), 32'({4'h4, 4'hE, 1'b0, 1'b0}));
    check("model_70_20", 32'(model(8'h70, 8'h20)), 32'({4'h3, 4'h0, 1'b0, 1'b0}));
    check("model_90_20", 32'(model(8'h90, 8'h20)), 32'({4'hD, 4'h0, 1'b0, 1'b0}));
    check("model_80_F0", 32'(model(8'h80, 8'hF0)), 32'({4'h8, 4'h0, 1'b0, 1'b1}));
    check("model_35_00", 32'(model(8'h35, 8'h00)), 32'({4'h0, 4'h0, 1'b1, 1'b0}));

    run_div(8'h62, 8'h11, 10);
    check("q_62_11", 32'({bus.quor, bus.quoi}), 32'h4E);
    run_div(8'h70, 8'h20, 10);
    run_div(8'h90, 8'h20, 10);
    check("q_90_20", 32'({bus.quor, bus.quoi}), 32'hD0);
    run_div(8'h80, 8'hF0, 10);
    check("ovf_80_F0", 32'({bus.quor, bus.ovf}), 32'h11);
    run_div(8'h35, 8'h00, 10);
    check("dz_35_00", 32'({bus.quor, bus.quoi, bus.div_zero, bus.ovf}), 32'h002);

    // done held through disabled cycles; start with enable low is not sampled
    run_div(8'h90, 8'h20, 10);
    enable    = 1'b0;
    bus.start = 1'b1;
    bus.a     = 8'h70;
    repeat (3) begin
      @(posedge clk); #1;
      check("done_hold", 32'(bus.done), 32'd1);
    end
    bus.start = 1'b0;
    enable    = 1'b1;
    @(posedge clk); #1;
    check("done_clear", 32'({bus.done, bus.busy}), 32'd0);

    // start ignored while busy, enable dropped for 5 cycles mid-DIV
    bus.start = 1'b1;
    bus.a     = 8'h62;
    bus.b     = 8'h11;
    exp_q.push_back(model(8'h62, 8'h11));
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat       = 0;
    busy_ok   = bus.busy;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      bus.start = (cyc == 4);
      bus.a     = (cyc == 4) ? 8'h70 : 8'h62;
      enable    = !(cyc >= 5 && cyc <= 9);
      @(posedge clk); #1;
      if (bus.done) begin
        lat = cyc;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
    end
    bus.start = 1'b0;
    enable    = 1'b1;
    check("en_latency", 32'(lat), 32'd15);
    check("en_busy", 32'(busy_ok), 32'd1);
    check("en_result", 32'({bus.quor, bus.quoi}), 32'h4E);
    @(posedge clk); #1;

    // reset in the middle of a division aborts it
    bus.start = 1'b1;
    bus.a     = 8'h62;
    bus.b     = 8'h11;
    exp_q.push_back(model(8'h62, 8'h11));
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_abort", 32'({bus.busy, bus.done, bus.quor, bus.quoi, bus.div_zero, bus.ovf}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen  = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.done) seen++;
    end
    check("no_done_after_reset", 32'(seen), 32'd0);
    run_div(8'h70, 8'h20, 10);
    check("q_after_reset", 32'({bus.quor, bus.quoi}), 32'h30);

    // random operand sweep, with regular divide-by-zero cases
    for (int i = 0; i < 2500; i++) begin
      ra = 8'($urandom);
      rb = (i % 50 == 0) ? 8'h00 : 8'($urandom);
      run_div(ra, rb, 10);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
